// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO block: per-bit direction, set/clear access to the output register and
// per-bit edge/level interrupts latched in a write-1-to-clear status register.
module wb_gpio_irq #(
   parameter int unsigned GPIO_WIDTH     = 8,
   parameter logic [31:0] GPIO_DIR_RESET = '0,
   parameter logic [31:0] GPIO_O_RESET   = '0,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned WB_DAT_WIDTH   = 32,
   parameter int unsigned WB_ADR_WIDTH   = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WB_ADR_WIDTH-1:0] wb_adr_i,
   input  logic [WB_DAT_WIDTH-1:0] wb_dat_i,
   input  logic                    wb_we_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   output logic                    wb_ack_o,
   output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
   inout  wire  [GPIO_WIDTH-1:0]   gpio_io,
   output logic                    irq
);

   localparam int unsigned W    = GPIO_WIDTH;
   localparam int unsigned CntW = $clog2(SYNC_STAGES + 2);

   localparam logic [3:0] AdrDataIn  = 4'd0;
   localparam logic [3:0] AdrDataOut = 4'd1;
   localparam logic [3:0] AdrDir     = 4'd2;
   localparam logic [3:0] AdrOutSet  = 4'd3;
   localparam logic [3:0] AdrOutClr  = 4'd4;
   localparam logic [3:0] AdrIrqEn   = 4'd5;
   localparam logic [3:0] AdrIrqEdge = 4'd6;
   localparam logic [3:0] AdrIrqPol  = 4'd7;
   localparam logic [3:0] AdrStatus  = 4'd8;

   logic [W-1:0]    dout_q, dir_q, en_q, edge_q, pol_q, status_q, prev_q;
   logic [W-1:0]    sync_q [SYNC_STAGES];
   logic [W-1:0]    data_in, wdata, rdata_w, w1c;
   logic [W-1:0]    rise, fall, edge_ev, lvl_ev, ev;
   logic [CntW-1:0] arm_q;
   logic            armed, ack_q, req, access, wr, cfg_wr;
   logic [3:0]      idx;
   logic            unused_bits;

   assign req      = wb_cyc_i & wb_stb_i;
   assign access   = req & ~ack_q;
   assign wr       = access & wb_we_i;
   assign idx      = wb_adr_i[5:2];
   assign wdata    = wb_dat_i[W-1:0];
   assign wb_ack_o = req & ack_q;
   assign unused_bits = ^{wb_adr_i, wb_dat_i};

   for (genvar g = 0; g < GPIO_WIDTH; g++) begin : g_pad
      assign gpio_io[g] = dir_q[g] ? dout_q[g] : 1'bz;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= gpio_io;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign data_in = sync_q[SYNC_STAGES-1];

   // Events stay masked until the synchronizer and prev hold real pin values.
   assign armed = (arm_q == CntW'(SYNC_STAGES + 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arm_q <= '0;
      end else if (!armed) begin
         arm_q <= arm_q + 1'b1;
      end
   end

   assign cfg_wr  = wr & ((idx == AdrDir) | (idx == AdrIrqEdge) | (idx == AdrIrqPol));
   assign rise    = data_in & ~prev_q;
   assign fall    = ~data_in & prev_q;
   assign edge_ev = (pol_q & rise) | (~pol_q & fall);
   assign lvl_ev  = ~(data_in ^ pol_q);
   assign ev      = ((edge_q & edge_ev) | (~edge_q & lvl_ev)) & ~dir_q & {W{armed & ~cfg_wr}};
   assign w1c     = (wr && idx == AdrStatus) ? wdata : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q   <= GPIO_O_RESET[W-1:0];
         dir_q    <= GPIO_DIR_RESET[W-1:0];
         en_q     <= '0;
         edge_q   <= '0;
         pol_q    <= '0;
         status_q <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr) begin
            case (idx)
               AdrDataOut: dout_q <= wdata;
               AdrDir:     dir_q  <= wdata;
               AdrOutSet:  dout_q <= dout_q | wdata;
               AdrOutClr:  dout_q <= dout_q & ~wdata;
               AdrIrqEn:   en_q   <= wdata;
               AdrIrqEdge: edge_q <= wdata;
               AdrIrqPol:  pol_q  <= wdata;
               default:    ;
            endcase
         end
         // A new event outranks a clear landing on the same bit.
         status_q <= (status_q & ~w1c) | ev;
         irq      <= |(status_q & en_q);
      end
   end

   always_comb begin
      rdata_w = '0;
      case (idx)
         AdrDataIn:  rdata_w = data_in;
         AdrDataOut: rdata_w = dout_q;
         AdrDir:     rdata_w = dir_q;
         AdrIrqEn:   rdata_w = en_q;
         AdrIrqEdge: rdata_w = edge_q;
         AdrIrqPol:  rdata_w = pol_q;
         AdrStatus:  rdata_w = status_q;
         default:    rdata_w = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_q    <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         ack_q <= access;
         if (access) wb_dat_o <= WB_DAT_WIDTH'(rdata_w);
      end
   end

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq: register table, hand-written interrupt sequences and
// random traffic compared cycle by cycle against a behavioural model.
module tb_wb_gpio_irq;

   localparam int unsigned W = 8;
   localparam int unsigned S = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic        wb_we_i = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_ack_o;
   logic [31:0] wb_dat_o;
   logic        irq;
   wire [W-1:0] gpio;
   logic [W-1:0] tb_val = 8'h30;

   // Behavioural model state.
   logic [7:0]  m_dout = '0, m_dir = '0, m_en = '0, m_edge = '0, m_pol = '0, m_status = '0;
   logic        m_irq = 1'b0, m_ack = 1'b0;
   logic [31:0] m_rdata = '0;
   logic [7:0]  hist [$];  // pin samples, newest first
   int          m_cycles = 0;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic        we;
      logic [3:0]  idx;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < W; g++) begin : g_drv
      assign gpio[g] = m_dir[g] ? 1'bz : tb_val[g];
   end

   wb_gpio_irq #(
      .GPIO_WIDTH (W),
      .SYNC_STAGES(S)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wb_adr_i(wb_adr_i),
      .wb_dat_i(wb_dat_i),
      .wb_we_i (wb_we_i),
      .wb_cyc_i(wb_cyc_i),
      .wb_stb_i(wb_stb_i),
      .wb_ack_o(wb_ack_o),
      .wb_dat_o(wb_dat_o),
      .gpio_io (gpio),
      .irq     (irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] reg_val(input logic [3:0] idx, input logic [7:0] din);
      case (idx)
         4'd0: return din;
         4'd1: return m_dout;
         4'd2: return m_dir;
         4'd5: return m_en;
         4'd6: return m_edge;
         4'd7: return m_pol;
         4'd8: return m_status;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      m_dout = '0; m_dir = '0; m_en = '0; m_edge = '0; m_pol = '0; m_status = '0;
      m_irq = 1'b0; m_ack = 1'b0; m_rdata = '0; m_cycles = 0;
      hist = {};
      for (int i = 0; i <= S; i++) hist.push_back(8'h00);
   endtask

   // One clock: predict from the current inputs, advance, then compare every output.
   task automatic cycle();
      logic        req, acc, wr, cfg_wr, n_irq;
      logic [3:0]  idx;
      logic [7:0]  wd, din, prv, ev, pin;
      logic [7:0]  n_dout, n_dir, n_en, n_edge, n_pol, n_status;
      logic [31:0] n_rdata;
      req    = wb_cyc_i & wb_stb_i;
      acc    = req && !m_ack;
      wr     = acc && wb_we_i;
      idx    = wb_adr_i[5:2];
      wd     = wb_dat_i[7:0];
      cfg_wr = wr && (idx == 4'd2 || idx == 4'd6 || idx == 4'd7);
      din    = hist[S-1];
      prv    = hist[S];
      ev     = '0;
      if (m_cycles >= S + 1 && !cfg_wr) begin
         for (int i = 0; i < W; i++) begin
            if (m_dir[i]) continue;
            if (m_edge[i]) ev[i] = (din[i] == m_pol[i]) && (prv[i] != m_pol[i]);
            else ev[i] = (din[i] == m_pol[i]);
         end
      end
      n_status = m_status;
      if (wr && idx == 4'd8) n_status = n_status & ~wd;
      n_status = n_status | ev;
      n_irq    = (m_status & m_en) != 0;
      n_rdata  = acc ? {24'h0, reg_val(idx, din)} : m_rdata;
      n_dout = m_dout; n_dir = m_dir; n_en = m_en; n_edge = m_edge; n_pol = m_pol;
      if (wr) begin
         case (idx)
            4'd1: n_dout = wd;
            4'd2: n_dir  = wd;
            4'd3: n_dout = m_dout | wd;
            4'd4: n_dout = m_dout & ~wd;
            4'd5: n_en   = wd;
            4'd6: n_edge = wd;
            4'd7: n_pol  = wd;
            default: ;
         endcase
      end
      pin = (m_dir & m_dout) | (~m_dir & tb_val);
      @(posedge clk);
      #1;
      m_dout = n_dout; m_dir = n_dir; m_en = n_en; m_edge = n_edge; m_pol = n_pol;
      m_status = n_status; m_irq = n_irq; m_ack = acc; m_rdata = n_rdata;
      hist.push_front(pin);
      void'(hist.pop_back());
      m_cycles++;
      #1;
      check("irq", irq, m_irq);
      check("ack", wb_ack_o, req & m_ack);
      check("dat_o", wb_dat_o, m_rdata);
      check("pins", gpio & m_dir, m_dout & m_dir);
   endtask

   task automatic bus(input logic we, input logic [3:0] idx, input logic [31:0] wd,
                      output logic [31:0] rd);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
      wb_adr_i = {26'h0, idx, 2'b00}; wb_dat_i = wd;
      check("ack_wait", wb_ack_o, 0);
      cycle();
      check("ack_1cyc", wb_ack_o, 1);
      rd = wb_dat_o;
      cycle();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic do_reset();
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", wb_ack_o, 0);
      check("rst_dat", wb_dat_o, 0);
      check("rst_irq", irq, 0);
      rst = 1'b1;
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int n, acks;

      tbl.push_back('{1'b0, 4'd1,  32'h0,         32'h00});
      tbl.push_back('{1'b0, 4'd2,  32'h0,         32'h00});
      tbl.push_back('{1'b0, 4'd5,  32'h0,         32'h00});
      tbl.push_back('{1'b0, 4'd6,  32'h0,         32'h00});
      tbl.push_back('{1'b0, 4'd7,  32'h0,         32'h00});
      tbl.push_back('{1'b1, 4'd1,  32'hA5,        32'h00});
      tbl.push_back('{1'b1, 4'd2,  32'h0F,        32'h00});
      tbl.push_back('{1'b0, 4'd1,  32'h0,         32'hA5});
      tbl.push_back('{1'b0, 4'd2,  32'h0,         32'h0F});
      tbl.push_back('{1'b1, 4'd1,  32'h00,        32'h00});
      tbl.push_back('{1'b1, 4'd3,  32'h81,        32'h00});
      tbl.push_back('{1'b0, 4'd1,  32'h0,         32'h81});
      tbl.push_back('{1'b1, 4'd4,  32'h01,        32'h00});
      tbl.push_back('{1'b0, 4'd1,  32'h0,         32'h80});
      tbl.push_back('{1'b0, 4'd3,  32'h0,         32'h00});
      tbl.push_back('{1'b0, 4'd4,  32'h0,         32'h00});
      tbl.push_back('{1'b0, 4'd12, 32'h0,         32'h00});
      tbl.push_back('{1'b1, 4'd9,  32'hFF,        32'h00});
      tbl.push_back('{1'b0, 4'd9,  32'h0,         32'h00});
      tbl.push_back('{1'b1, 4'd6,  32'h1F3,       32'h00});
      tbl.push_back('{1'b0, 4'd6,  32'h0,         32'hF3});
      tbl.push_back('{1'b1, 4'd7,  32'hFFFF_FF5A, 32'h00});
      tbl.push_back('{1'b0, 4'd7,  32'h0,         32'h5A});
      tbl.push_back('{1'b1, 4'd0,  32'hFF,        32'h00});
      tbl.push_back('{1'b0, 4'd1,  32'h0,         32'h80});
      tbl.push_back('{1'b0, 4'd2,  32'h0,         32'h0F});
      tbl.push_back('{1'b1, 4'd6,  32'h0,         32'h00});
      tbl.push_back('{1'b1, 4'd7,  32'h0,         32'h00});

      tb_val = 8'h30;
      do_reset();

      foreach (tbl[k]) begin
         bus(tbl[k].we, tbl[k].idx, tbl[k].wd, rd);
         if (!tbl[k].we) check($sformatf("tbl%0d", k), rd, tbl[k].exp);
      end

      // Low nibble driven from DATA_OUT, high nibble left to the bench.
      bus(1'b1, 4'd1, 32'hA5, rd);
      check("pins_lo", {28'h0, gpio[3:0]}, 32'h5);
      repeat (S + 1) cycle();
      bus(1'b0, 4'd0, 32'h0, rd);
      check("data_in", rd, 32'h35);

      // Rising edge on bit 2.
      tb_val = 8'hFB;
      bus(1'b1, 4'd2, 32'h00, rd);
      bus(1'b1, 4'd6, 32'h04, rd);
      bus(1'b1, 4'd7, 32'h04, rd);
      bus(1'b1, 4'd5, 32'h04, rd);
      repeat (S + 2) cycle();
      bus(1'b1, 4'd8, 32'hFF, rd);
      bus(1'b0, 4'd8, 32'h0, rd);
      check("edge_pre_status", rd, 32'h00);
      tb_val = 8'hFF;
      n = 1;
      while (n <= 10) begin
         cycle();
         if (irq) break;
         n++;
      end
      check("edge_irq_latency", n, S + 2);
      bus(1'b0, 4'd8, 32'h0, rd);
      check("edge_status", rd, 32'h04);
      bus(1'b1, 4'd8, 32'h04, rd);
      check("edge_irq_clear", irq, 0);
      bus(1'b0, 4'd8, 32'h0, rd);
      check("edge_status_clr", rd, 32'h00);

      // Level-low on bit 0: clear re-sets, event beats a same-cycle clear.
      tb_val = 8'hFE;
      bus(1'b1, 4'd6, 32'h00, rd);
      bus(1'b1, 4'd7, 32'h00, rd);
      bus(1'b1, 4'd5, 32'h01, rd);
      repeat (S + 2) cycle();
      bus(1'b1, 4'd8, 32'hFF, rd);
      bus(1'b0, 4'd8, 32'h0, rd);
      check("lvl_reset", rd, 32'h01);
      bus(1'b1, 4'd8, 32'h01, rd);
      check("lvl_setwins_irq", irq, 1);
      bus(1'b0, 4'd8, 32'h0, rd);
      check("lvl_status", rd, 32'h01);

      // Held request is acked every second cycle.
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h4;
      acks = 0;
      repeat (4) begin
         cycle();
         acks += int'(wb_ack_o);
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      check("held_acks", acks, 2);

      // Reset in the middle of an access kills the ack.
      tb_val = 8'hFF;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h8;
      cycle();
      rst = 1'b0;
      #1;
      check("abort_ack", wb_ack_o, 0);
      do_reset();

      // Pins high through reset: no spurious status once armed.
      bus(1'b1, 4'd6, 32'hFF, rd);
      bus(1'b1, 4'd7, 32'hFF, rd);
      bus(1'b1, 4'd5, 32'hFF, rd);
      repeat (S + 2) cycle();
      bus(1'b0, 4'd8, 32'h0, rd);
      check("arm_status", rd, 32'h00);
      bus(1'b0, 4'd12, 32'h0, rd);
      check("idx12", rd, 32'h00);
      check("arm_irq", irq, 0);

      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 5))
            0, 1: begin
               tb_val = 8'($urandom);
               cycle();
            end
            2: cycle();
            default: bus(1'($urandom), 4'($urandom_range(0, 15)), $urandom, rd);
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_gpio_irq.md
WB_GPIO_IRQ -- requirements
Module: wb_gpio_irq

Interface
REQ-001 Parameter GPIO_WIDTH, default 8, number of GPIO bits (legal 1..32).
REQ-002 Parameter GPIO_DIR_RESET, default 0, reset value of DIR register.
REQ-003 Parameter GPIO_O_RESET, default 0, reset value of DATA_OUT register.
REQ-004 Parameter SYNC_STAGES, default 2, input synchronizer depth (legal 2..4).
REQ-005 Parameter WB_DAT_WIDTH, default 32, and WB_ADR_WIDTH, default 32, set the Wishbone bus widths.
REQ-006 Ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wb_adr_i  in  WB_ADR_WIDTH  byte address; only [5:2] decoded.
- wb_dat_i  in  WB_DAT_WIDTH  write data.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  WB_DAT_WIDTH  registered read data.
- gpio_io  inout  GPIO_WIDTH  tristate pins.
- irq  out  1  registered interrupt request.

Function
REQ-007 Register map, word index wb_adr_i[5:2]: 0 DATA_IN (RO); 1 DATA_OUT (RW); 2 DIR (RW, 1=output); 3 OUT_SET (WO, 1 sets DATA_OUT bit); 4 OUT_CLR (WO, 1 clears DATA_OUT bit); 5 IRQ_EN (RW); 6 IRQ_EDGE (RW, 1=edge, 0=level); 7 IRQ_POL (RW, 1=rising/high, 0=falling/low); 8 IRQ_STATUS (RO, write-1-to-clear).
REQ-008 Indices 9..15 and the write-only registers read as 0; writes to them and to DATA_IN are ignored; all are still acked.
REQ-009 Read data bits at and above GPIO_WIDTH are 0; write data bits at and above GPIO_WIDTH are ignored.
REQ-010 Request = wb_cyc_i & wb_stb_i; internal ack register sets on the clock after a request while ack is 0, and clears the following clock.
REQ-011 wb_ack_o = wb_cyc_i & wb_stb_i & ack; single-wait-state access; a held request is acked every second cycle.
REQ-012 Read data is loaded into wb_dat_o on the same edge ack sets; wb_dat_o holds its value otherwise.
REQ-013 Register writes take effect on the edge ack sets; a request dropped before that edge has no effect.
REQ-014 Pin i is driven with DATA_OUT[i] when DIR[i]=1, else high-Z.
REQ-015 Each pin passes through a SYNC_STAGES flop chain; DATA_IN is the chain output, so the pin-to-DATA_IN latency is SYNC_STAGES cycles.
REQ-016 A prev register holds the synchronized value delayed one cycle, for edge detection.
REQ-017 Event on bit i exists only when DIR[i]=0:
- edge mode: sync/prev transition matches IRQ_POL[i];
- level mode: sync equals IRQ_POL[i].
REQ-018 IRQ_STATUS[i] sets on an event, regardless of IRQ_EN; it clears only via write-1 to index 8.
REQ-019 Simultaneous event and W1C on the same bit in one cycle: set wins.
REQ-020 Level-mode status cleared while the level persists re-sets on the next cycle.
REQ-021 irq is registered as |(IRQ_STATUS & IRQ_EN), one cycle after the status/enable change.
REQ-022 A write changing DIR, IRQ_EDGE or IRQ_POL does not generate an event in the same cycle.

Reset
REQ-023 On rst low, asynchronously:
- DATA_OUT=GPIO_O_RESET, DIR=GPIO_DIR_RESET;
- IRQ_EN, IRQ_EDGE, IRQ_POL, IRQ_STATUS, synchronizer, prev = 0;
- ack=0, wb_dat_o=0, irq=0.
REQ-024 After rst deasserts, an arming counter suppresses all events for SYNC_STAGES+1 cycles, so a pin high at reset gives no spurious edge.
REQ-025 Reset asserted mid-access aborts it; no ack is issued for that request.

Verification
REQ-026 Write 0xA5 to DATA_OUT, 0x0F to DIR -> pins[3:0]=0101, pins[7:4]=Z; each write acked exactly 1 cycle after request.
REQ-027 DATA_OUT=0x00; write 0x81 to OUT_SET, then 0x01 to OUT_CLR -> DATA_OUT reads 0x81 then 0x80.
REQ-028 Enable rising edge on bit 2 (EDGE=0x04, POL=0x04, EN=0x04); drive pin2 0->1 -> STATUS=0x04 within SYNC_STAGES+1 cycles, irq=1 next cycle; W1C 0x04 -> irq=0.
REQ-029 Level-low mode on bit 0 with pin held low; W1C 0x01 -> STATUS reads 0x01 again; same-cycle event+W1C keeps bit set.
REQ-030 Hold all pins high through reset, rising-edge mode on all bits -> STATUS stays 0x00 after arming; read index 12 -> 0x00000000, acked.
